// File: rtl/als_spi_reader_pkg.sv
// Purpose: shared definitions for the ambient-light SPI reader (state codes, frame layout, decode).
// Latency: none; constants, types and a combinational helper only.
// Backpressure: none.
package als_spi_reader_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SETUP      = 3'd1;
    localparam logic [2:0] ST_SHIFT_LOW  = 3'd2;
    localparam logic [2:0] ST_SHIFT_HIGH = 3'd3;
    localparam logic [2:0] ST_HOLD       = 3'd4;
    localparam logic [2:0] ST_WAIT       = 3'd5;

    // Frame layout: 2 leading guard zeros, 8 data bits, 4 trailing guard zeros, 2 don't-care bits
    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 13;
    localparam int DATA_LSB   = 6;

    localparam logic [FRAME_BITS-1:0] GUARD_MASK_HI = 16'hC000;  // bits 15:14
    localparam logic [FRAME_BITS-1:0] GUARD_MASK_LO = 16'h003C;  // bits 5:2

    typedef struct packed {
        logic [7:0] data;
        logic       frame_error;
    } als_sample_t;

    function automatic als_sample_t decode_frame(input logic [FRAME_BITS-1:0] frame);
        als_sample_t s;
        s.data        = frame[DATA_MSB:DATA_LSB];
        s.frame_error = |(frame & (GUARD_MASK_HI | GUARD_MASK_LO));
        return s;
    endfunction

endpackage

// File: rtl/als_spi_reader_sync_2ff.sv
// Purpose: two-flop synchroniser for asynchronous level inputs, synchronous reset to 0.
// Latency: 2 i_clock cycles from input change to o_q.
// Backpressure: none; free-running.
//
// Ports:
//   i_clock  - destination clock
//   i_reset  - synchronous active-high reset
//   i_d      - asynchronous input bus
//   o_q      - synchronised output bus
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/als_spi_reader.sv
// Purpose: periodic 16-SCLK SPI frame reader for the ambient-light ADC, emits 8-bit sample + guard check.
// Latency: o_valid fires F = SETUP + 32*HALF + HOLD cycles after CS_N falls, on the CS_N rise edge.
// Backpressure: none; o_valid is a one-cycle pulse the consumer must take when it appears.
//
// Ports:
//   i_clock, i_reset     - sole clock, synchronous active-high reset (inverted reset-stretcher output)
//   i_enable             - level; frames repeat every SAMPLE_PERIOD_CYCLES while high
//   i_miso               - asynchronous ADC data line
//   o_cs_n, o_sclk       - PMOD chip select (active low) and serial clock (idle high)
//   o_data, o_valid      - last captured light value and its one-cycle update strobe
//   o_frame_error        - guard bits were nonzero in the frame that produced o_data
//   o_busy               - high while CS_N is low
module als_spi_reader
    import als_spi_reader_pkg::*;
#(
    parameter int SCLK_HALF_CYCLES     = 16,
    parameter int CS_SETUP_CYCLES      = 4,
    parameter int CS_HOLD_CYCLES       = 4,
    parameter int SAMPLE_PERIOD_CYCLES = 125000
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_miso,
    output logic       o_cs_n,
    output logic       o_sclk,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    // One phase counter is shared by SETUP, both SCLK halves and HOLD, so size it for the longest.
    localparam int PH_MAX_A = (SCLK_HALF_CYCLES > CS_SETUP_CYCLES) ? SCLK_HALF_CYCLES : CS_SETUP_CYCLES;
    localparam int PH_MAX   = (PH_MAX_A > CS_HOLD_CYCLES) ? PH_MAX_A : CS_HOLD_CYCLES;
    localparam int CW       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int PW       = (SAMPLE_PERIOD_CYCLES > 1) ? $clog2(SAMPLE_PERIOD_CYCLES) : 1;
    localparam int BW       = $clog2(FRAME_BITS + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PER_LAST   = PW'(SAMPLE_PERIOD_CYCLES - 1);
    localparam logic [BW-1:0] BITS_ALL   = BW'(FRAME_BITS);

    logic [2:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_pcnt;
    logic [BW-1:0]         r_bits;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic [7:0]            r_data;
    logic                  r_valid;
    logic                  r_frame_error;
    logic                  r_busy;

    logic                  w_miso_sync;
    als_sample_t           w_sample;

    sync_2ff #(
        .WIDTH (1)
    ) u_miso_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_miso),
        .o_q     (w_miso_sync)
    );

    assign w_sample = decode_frame(r_shift);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_pcnt        <= '0;
            r_bits        <= '0;
            r_shift       <= '0;
            r_cs_n        <= 1'b1;
            r_sclk        <= 1'b1;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // Period counter saturates at its terminal value; if the period is shorter than
            // a frame, WAIT then sees the terminal value on entry and lasts a single cycle.
            if (r_pcnt != PER_LAST) begin
                r_pcnt <= r_pcnt + PW'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_pcnt  <= '0;
                        r_bits  <= '0;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state <= ST_SHIFT_LOW;
                        r_sclk  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_SHIFT_LOW: begin
                    if (r_cnt == HALF_LAST) begin
                        // Capture on the rising SCLK edge; the ADC changed data a half period ago.
                        r_state <= ST_SHIFT_HIGH;
                        r_sclk  <= 1'b1;
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_miso_sync};
                        r_bits  <= r_bits + BW'(1);
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_SHIFT_HIGH: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_bits == BITS_ALL) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_SHIFT_LOW;
                            r_sclk  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state       <= ST_WAIT;
                        r_cs_n        <= 1'b1;
                        r_busy        <= 1'b0;
                        r_data        <= w_sample.data;
                        r_frame_error <= w_sample.frame_error;
                        r_valid       <= 1'b1;
                        r_cnt         <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                ST_WAIT: begin
                    if (r_pcnt == PER_LAST) begin
                        if (i_enable) begin
                            r_state <= ST_SETUP;
                            r_cs_n  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_pcnt  <= '0;
                            r_bits  <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_cs_n        = r_cs_n;
    assign o_sclk        = r_sclk;
    assign o_data        = r_data;
    assign o_valid       = r_valid;
    assign o_frame_error = r_frame_error;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_als_spi_reader.sv
// Purpose: randomized scoreboard bench for als_spi_reader with a behavioural ADC model.
// Latency: checks valid-to-CS_N-rise alignment, frame length and frame spacing.
// Backpressure: none; a monitor pops expected samples whenever o_valid pulses.
module tb_als_spi_reader;

    localparam int HALF  = 4;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int PER_A = 200;
    localparam int PER_B = 100;
    localparam int F     = SETUP + 32 * HALF + HOLD;   // 132

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       en_a, en_b;
    logic       miso_a, miso_b;
    logic       cs_n_a, sclk_a, valid_a, ferr_a, busy_a;
    logic       cs_n_b, sclk_b, valid_b, ferr_b, busy_b;
    logic [7:0] data_a, data_b;

    always #5 clk = ~clk;

    als_spi_reader #(
        .SCLK_HALF_CYCLES     (HALF),
        .CS_SETUP_CYCLES      (SETUP),
        .CS_HOLD_CYCLES       (HOLD),
        .SAMPLE_PERIOD_CYCLES (PER_A)
    ) u_dut_a (
        .i_clock       (clk),
        .i_reset       (rst_a),
        .i_enable      (en_a),
        .i_miso        (miso_a),
        .o_cs_n        (cs_n_a),
        .o_sclk        (sclk_a),
        .o_data        (data_a),
        .o_valid       (valid_a),
        .o_frame_error (ferr_a),
        .o_busy        (busy_a)
    );

    als_spi_reader #(
        .SCLK_HALF_CYCLES     (HALF),
        .CS_SETUP_CYCLES      (SETUP),
        .CS_HOLD_CYCLES       (HOLD),
        .SAMPLE_PERIOD_CYCLES (PER_B)
    ) u_dut_b (
        .i_clock       (clk),
        .i_reset       (rst_b),
        .i_enable      (en_b),
        .i_miso        (miso_b),
        .o_cs_n        (cs_n_b),
        .o_sclk        (sclk_b),
        .o_data        (data_b),
        .o_valid       (valid_b),
        .o_frame_error (ferr_b),
        .o_busy        (busy_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    int          cyc = 0;
    bit          mon_on = 1'b0;
    bit          abort_a = 1'b0;
    logic [15:0] word_q[$];
    exp_t        exp_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx = 0;
    int          fall_times[$];
    int          fall_cnt = 0;
    int          n_valid = 0;
    int          b_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: each SCLK fall presents the next frame bit, MSB first.
    always @(negedge sclk_a) begin
        if (mon_on && !cs_n_a && bit_idx < 16) begin
            miso_a = cur_word[15 - bit_idx];
            bit_idx++;
        end
    end

    // DUT A frame monitor: loads the ADC word on CS_N fall, checks frame shape on CS_N rise.
    bit prev_cs_a = 1'b1, prev_sclk_a = 1'b1;
    int low_a = 0, rises_a = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_cs_a && !cs_n_a) begin
                exp_t e;
                if (word_q.size() > 0) cur_word = word_q.pop_front();
                else cur_word = 16'($urandom);
                bit_idx = 0;
                e.data = cur_word[13:6];
                e.ferr = (cur_word[15:14] != 2'b00) || (cur_word[5:2] != 4'b0000);
                exp_q.push_back(e);
                fall_times.push_back(cyc);
                fall_cnt++;
                low_a   = 1;
                rises_a = 0;
                abort_a = 1'b0;
                check("busy_at_cs_fall", {31'd0, busy_a}, 32'd1);
            end else if (!cs_n_a) begin
                low_a++;
                if (sclk_a && !prev_sclk_a) rises_a++;
            end else if (!prev_cs_a && cs_n_a) begin
                if (!abort_a) begin
                    check("cs_low_cycles", low_a, F);
                    check("sclk_rises", rises_a, 16);
                    check("valid_at_cs_rise", {31'd0, valid_a}, 32'd1);
                    check("busy_at_cs_rise", {31'd0, busy_a}, 32'd0);
                end
                abort_a = 1'b0;
            end
            prev_cs_a   = cs_n_a;
            prev_sclk_a = sclk_a;
        end
    end

    // Scoreboard monitor for DUT A.
    always @(negedge clk) begin
        if (mon_on && valid_a) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data", {24'd0, data_a}, {24'd0, e.data});
                check("frame_error", {31'd0, ferr_a}, {31'd0, e.ferr});
            end
        end
    end

    // DUT B: period shorter than a frame, MISO held high -> every frame reads 0xFF with guard error.
    bit prev_cs_b = 1'b1;
    int low_b = 0, high_b = 0;
    always @(negedge clk) begin
        if (mon_on) begin
            if (prev_cs_b && !cs_n_b) begin
                if (b_frames > 0) check("b_cs_high_gap", high_b, 1);
                low_b = 1;
            end else if (!cs_n_b) begin
                low_b++;
            end else if (!prev_cs_b && cs_n_b) begin
                check("b_cs_low_cycles", low_b, F);
                check("b_valid", {31'd0, valid_b}, 32'd1);
                check("b_data", {24'd0, data_b}, 32'hFF);
                check("b_frame_error", {31'd0, ferr_b}, 32'd1);
                check("b_busy_at_rise", {31'd0, busy_b}, 32'd0);
                b_frames++;
                high_b = 1;
            end else begin
                high_b++;
            end
            prev_cs_b = cs_n_b;
        end
    end

    task automatic wait_valids(input int target, input int budget, input string name);
        for (int i = 0; i < budget && n_valid < target; i++) @(negedge clk);
        if (n_valid < target) check({name, "_timeout"}, n_valid, target);
    endtask

    task automatic wait_fall(input int target, input int budget, input string name);
        for (int i = 0; i < budget && fall_cnt < target; i++) @(negedge clk);
        if (fall_cnt < target) check({name, "_timeout"}, fall_cnt, target);
    endtask

    initial begin
        int en_cyc, base, f0, nv0, rel_cyc;
        rst_a = 1'b1; rst_b = 1'b1;
        en_a = 1'b0;  en_b = 1'b0;
        miso_a = 1'b0; miso_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, cs_n_a}, 32'd1);
        check("rst_sclk", {31'd0, sclk_a}, 32'd1);
        check("rst_data", {24'd0, data_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_ferr", {31'd0, ferr_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        mon_on = 1'b1;
        en_b = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_cs", {31'd0, cs_n_a}, 32'd1);

        // First frame 0xA5, then periodic 0x00, 0xFF, 0x3C, then 0x12 with guard bit 14 set.
        word_q.push_back(16'h2940 | 16'($urandom_range(0, 3)));
        word_q.push_back(16'h0000);
        word_q.push_back(16'h3FC0 | 16'($urandom_range(0, 3)));
        word_q.push_back(16'h0F00);
        word_q.push_back(16'h4480);
        for (int i = 0; i < 12; i++) word_q.push_back(16'($urandom));

        en_a = 1'b1;
        en_cyc = cyc;
        wait_valids(5, 5 * PER_A + 300, "periodic");
        if (fall_times.size() >= 5) begin
            check("first_fall_latency", fall_times[0], en_cyc + 1);
            for (int i = 1; i < 5; i++)
                check("fall_spacing", fall_times[i] - fall_times[i-1], PER_A);
        end else begin
            check("fall_count", fall_times.size(), 5);
        end

        // Drop enable 50 cycles into a frame: it must still finish, then go quiet.
        base = fall_cnt;
        wait_fall(base + 1, PER_A + 50, "drop_fall");
        repeat (50) @(negedge clk);
        en_a = 1'b0;
        nv0 = n_valid;
        wait_valids(nv0 + 1, 300, "drop_valid");
        f0 = fall_cnt;
        repeat (450) @(negedge clk);
        check("no_fall_after_disable", fall_cnt, f0);
        check("cs_idle_after_disable", {31'd0, cs_n_a}, 32'd1);

        // Reset 70 cycles into a frame: frame discarded, fresh frame right after release.
        en_a = 1'b1;
        base = fall_cnt;
        wait_fall(base + 1, 20, "rst_fall");
        repeat (70) @(negedge clk);
        nv0 = n_valid;
        abort_a = 1'b1;
        exp_q.delete();
        rst_a = 1'b1;
        @(negedge clk);
        check("midrst_cs_n", {31'd0, cs_n_a}, 32'd1);
        check("midrst_sclk", {31'd0, sclk_a}, 32'd1);
        check("midrst_data", {24'd0, data_a}, 32'd0);
        check("midrst_valid", {31'd0, valid_a}, 32'd0);
        check("midrst_ferr", {31'd0, ferr_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        rst_a = 1'b0;
        rel_cyc = cyc;
        base = fall_cnt;
        wait_fall(base + 1, 20, "post_rst_fall");
        if (fall_cnt > base) check("post_rst_fall_latency", fall_times[fall_times.size()-1], rel_cyc + 1);
        check("no_valid_from_aborted", n_valid, nv0);

        // A few more random frames, then stop and drain.
        wait_valids(nv0 + 4, 4 * PER_A + 300, "random");
        en_a = 1'b0;
        repeat (PER_A + 50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("b_frames_seen", {31'd0, b_frames >= 3}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "global timeout");
    end

endmodule
